// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM encoding and baud divisor helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Clocks per bit period; the receiver derives its divisor the same way.
    function automatic int bps_cnt(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering words for the UART transmitter.
// Pointers carry one extra wrap bit so level = wr - rd distinguishes full from empty.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

    assign level_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (level_o == (AW+1)'(DEPTH));
    assign empty_o = (level_o == '0);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: FIFO front end feeding a start/data/parity/stop serialiser.
// Queued words are chained from the last stop cycle straight into the next start bit.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
    localparam int CW      = $clog2(BPS_CNT);

    tx_state_e            state_q;
    logic [CW-1:0]        clk_cnt_q;
    logic [3:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 txd_q;
    logic                 busy_q;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 bit_last;
    logic                 stop_done;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .push_i  (tx_valid & tx_ready),
        .din_i   (tx_data),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign tx_ready  = !fifo_full;
    assign bit_last  = (clk_cnt_q == CW'(BPS_CNT - 1));
    assign stop_done = (state_q == ST_STOP) && bit_last && (bit_cnt_q == 4'(STOP_BITS - 1));
    assign fifo_pop  = !fifo_empty && ((state_q == ST_IDLE) || stop_done);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else if (fifo_pop) begin
            // Parity latched from the popped word so later tx_data changes cannot affect it.
            shift_q   <= fifo_dout;
            par_q     <= (^fifo_dout) ^ 1'(PARITY == PAR_ODD);
            txd_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ST_START;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else if (state_q != ST_IDLE) begin
            clk_cnt_q <= bit_last ? '0 : clk_cnt_q + 1'b1;
            if (bit_last) begin
                case (state_q)
                    ST_START: begin
                        state_q <= ST_DATA;
                        txd_q   <= shift_q[0];
                    end
                    ST_DATA: begin
                        if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                            bit_cnt_q <= '0;
                            if (PARITY != PAR_NONE) begin
                                state_q <= ST_PARITY;
                                txd_q   <= par_q;
                            end else begin
                                state_q <= ST_STOP;
                                txd_q   <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            shift_q   <= shift_q >> 1;
                            txd_q     <= shift_q[1];
                        end
                    end
                    ST_PARITY: begin
                        state_q <= ST_STOP;
                        txd_q   <= 1'b1;
                    end
                    ST_STOP: begin
                        if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                            state_q   <= ST_IDLE;
                            busy_q    <= 1'b0;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign uart_txd = txd_q;
    assign tx_busy  = busy_q;

endmodule
